// File: rtl/stack_ctrl.sv
// ---------------------------------------------------------------------------
// stack_ctrl
//   Sequencer between the control unit and the stack pointer register (SP).
//   Accepts push/pop requests, drives the data-memory stack segment and
//   produces new_top, which SP loads on every clock edge. new_top therefore
//   mirrors sp_top on every cycle that does not move the pointer.
//
//   Optional feature: define STACK_BOUNDS_CHECK_EN to reject pushes into a
//   full stack and pops from an empty one (sticky err, cleared by err_clr).
//   Without it, sp_top +/- 1 wraps modulo 2^DW and err is tied low.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req_valid  request present
//   req_ready  request can be accepted (IDLE only)
//   req_op     0 = push, 1 = pop
//   push_data  word to push, captured at accept
//   sp_top     current SP value (next free word)
//   new_top    next SP value, to SP input
//   mem_addr   data-memory word address
//   mem_we     data-memory write strobe
//   mem_re     data-memory read strobe
//   mem_wdata  data-memory write data
//   mem_rdata  data-memory read data, valid one cycle after mem_re
//   pop_data   last popped word
//   pop_valid  one-cycle pulse, pop_data updated
//   err        sticky overflow/underflow flag
//   err_clr    synchronous clear of err
//
// States
//   state  | meaning
//   IDLE   | ready for a request; new_top follows sp_top
//   PUSH   | write latched word at sp_top, advance SP
//   POP_RD | read word at sp_top-1, retreat SP
//   POP_WB | capture read data; pop_valid pulses next cycle
// ---------------------------------------------------------------------------
module stack_ctrl #(
  parameter int            DW          = 32,
  parameter logic [DW-1:0] STACK_BASE  = 256,
  parameter logic [DW-1:0] STACK_LIMIT = 511
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_op,
  input  logic [DW-1:0] push_data,
  input  logic [DW-1:0] sp_top,
  output logic [DW-1:0] new_top,
  output logic [DW-1:0] mem_addr,
  output logic          mem_we,
  output logic          mem_re,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] pop_data,
  output logic          pop_valid,
  output logic          err,
  input  logic          err_clr
);

  localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, PUSH, POP_RD, POP_WB} state_t;

  state_t        state;
  logic [DW-1:0] data_q;
  logic          ovf;
  logic          unf;

`ifdef STACK_BOUNDS_CHECK_EN
  localparam logic [DW-1:0] FULL_TOP = STACK_LIMIT + ONE;

  assign ovf = (state == PUSH)   && (sp_top == FULL_TOP);
  assign unf = (state == POP_RD) && (sp_top == STACK_BASE);

  // Setting wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (ovf || unf) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end
`else
  logic unused_cfg;

  assign ovf        = 1'b0;
  assign unf        = 1'b0;
  assign err        = 1'b0;
  assign unused_cfg = ^{err_clr, STACK_LIMIT};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      data_q    <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
    end else begin
      pop_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            data_q <= push_data;
            state  <= req_op ? POP_RD : PUSH;
          end
        end
        PUSH: state <= IDLE;
        // A rejected pop has nothing to write back.
        POP_RD: state <= unf ? IDLE : POP_WB;
        POP_WB: begin
          pop_data  <= mem_rdata;
          pop_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The memory strobes and new_top are decoded from state and the live
  // sp_top rather than registered: SP loads every cycle, so new_top has to
  // follow sp_top in the same cycle, and decoding from the asynchronously
  // reset state makes the strobes fall the instant rst rises.
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    new_top   = sp_top;
    if (rst) begin
      new_top = STACK_BASE;
    end else begin
      case (state)
        PUSH: begin
          if (!ovf) begin
            mem_we    = 1'b1;
            mem_addr  = sp_top;
            mem_wdata = data_q;
            new_top   = sp_top + ONE;
          end
        end
        POP_RD: begin
          if (!unf) begin
            mem_re   = 1'b1;
            mem_addr = sp_top - ONE;
            new_top  = sp_top - ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state == IDLE) && !rst;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl. The environment holds the SP register (loads
// new_top every edge) and a word memory with one-cycle read latency. A
// reference model keeps a LIFO of pushed words plus a per-cycle table of
// what each accepted request must produce, and a negedge process compares
// the DUT against it every cycle. Directed sequences pin literal values.
module tb_stack_ctrl;

  localparam int          DW    = 32;
  localparam logic [31:0] BASE  = 32'd256;
  localparam logic [31:0] LIMIT = 32'd511;

`ifdef STACK_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_op;
  logic [DW-1:0] push_data;
  logic [DW-1:0] sp_top = 32'h1357_9BDF;
  logic [DW-1:0] new_top;
  logic [DW-1:0] mem_addr;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] pop_data;
  logic          pop_valid;
  logic          err;
  logic          err_clr;

  stack_ctrl #(.DW(DW), .STACK_BASE(BASE), .STACK_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .push_data(push_data), .sp_top(sp_top),
    .new_top(new_top), .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pop_data(pop_data),
    .pop_valid(pop_valid), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Environment: SP register and data memory.
  logic        sp_load = 1'b0;
  logic [31:0] sp_load_val = '0;
  logic [31:0] mem [0:1023];

  always @(posedge clk) begin
    sp_top <= sp_load ? sp_load_val : new_top;
    if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[9:0]];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  typedef struct {
    bit          busy;
    bit          we;
    bit          re;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delta;
    bit          pv;
    logic [31:0] pd;
    bit          err_ev;
  } exp_t;

  exp_t        sched [int];
  logic [31:0] golden [$];
  logic [31:0] m_pop_data = '0;
  bit          m_err = 1'b0;
  int          cyc = 0;

  always @(negedge clk) begin
    exp_t        e;
    exp_t        a;
    exp_t        b;
    logic [31:0] exp_nt;
    e = '{default: '0};
    if (sched.exists(cyc)) begin
      e = sched[cyc];
      sched.delete(cyc);
    end
    if (rst) begin
      chk ("m_rst_new_top", new_top, BASE);
      chk1("m_rst_ready", req_ready, 1'b0);
      chk1("m_rst_we", mem_we, 1'b0);
      chk1("m_rst_re", mem_re, 1'b0);
      chk ("m_rst_addr", mem_addr, 32'd0);
      chk ("m_rst_wdata", mem_wdata, 32'd0);
      chk1("m_rst_pop_valid", pop_valid, 1'b0);
      chk ("m_rst_pop_data", pop_data, 32'd0);
      chk1("m_rst_err", err, 1'b0);
      sched.delete();
      golden.delete();
      m_pop_data = '0;
      m_err      = 1'b0;
    end else begin
      exp_nt = sp_top + e.delta;
      chk1("m_ready", req_ready, !e.busy);
      chk1("m_we", mem_we, e.we);
      chk1("m_re", mem_re, e.re);
      if (e.we) begin
        chk("m_wr_addr", mem_addr, e.addr);
        chk("m_wdata", mem_wdata, e.wdata);
      end
      if (e.re) chk("m_rd_addr", mem_addr, e.addr);
      chk ("m_new_top", new_top, exp_nt);
      chk1("m_pop_valid", pop_valid, e.pv);
      if (e.pv) m_pop_data = e.pd;
      chk ("m_pop_data", pop_data, m_pop_data);
      chk1("m_err", err, m_err);

      if (e.err_ev) m_err = 1'b1;
      else if (err_clr && BOUNDS) m_err = 1'b0;

      if (!e.busy && req_valid) begin
        a = '{default: '0};
        a.busy = 1'b1;
        if (!req_op) begin
          if (BOUNDS && sp_top == LIMIT + 1) begin
            a.err_ev = 1'b1;
          end else begin
            a.we    = 1'b1;
            a.addr  = sp_top;
            a.wdata = push_data;
            a.delta = 1;
            golden.push_back(push_data);
          end
          sched[cyc+1] = a;
        end else begin
          if (BOUNDS && sp_top == BASE) begin
            a.err_ev = 1'b1;
            sched[cyc+1] = a;
          end else begin
            a.re    = 1'b1;
            a.addr  = sp_top - 1;
            a.delta = -1;
            sched[cyc+1] = a;
            b = '{default: '0};
            b.busy = 1'b1;
            sched[cyc+2] = b;
            b = '{default: '0};
            b.pv = 1'b1;
            b.pd = (golden.size() > 0) ? golden.pop_back() : 32'd0;
            sched[cyc+3] = b;
          end
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  // Hold a request until the DUT takes it; returns #1 after the accepting
  // edge, i.e. early in the first cycle of the operation.
  task automatic do_op(input logic op, input logic [31:0] d);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    req_valid = 1'b1;
    req_op    = op;
    push_data = d;
    while (!acc && n < 8) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL handshake_timeout: op %0d not accepted within %0d cycles", op, n);
    end
  endtask

  initial begin
    int   depth;
    logic op;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 1'b0;
    push_data = '0;
    err_clr   = 1'b0;

    // Reset with an arbitrary SP value present.
    #2;
    chk ("rst_new_top", new_top, 32'd256);
    chk1("rst_ready", req_ready, 1'b0);
    chk1("rst_we", mem_we, 1'b0);
    chk1("rst_re", mem_re, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk1("post_rst_ready", req_ready, 1'b1);
    chk1("post_rst_we", mem_we, 1'b0);
    chk1("post_rst_re", mem_re, 1'b0);
    chk ("post_rst_sp", sp_top, 32'd256);

    // Single push.
    do_op(1'b0, 32'hDEADBEEF);
    #1;
    chk1("push_we", mem_we, 1'b1);
    chk ("push_addr", mem_addr, 32'd256);
    chk ("push_wdata", mem_wdata, 32'hDEADBEEF);
    chk ("push_new_top", new_top, 32'd257);
    @(posedge clk);
    #2;
    chk ("push_sp", sp_top, 32'd257);
    chk ("push_track", new_top, 32'd257);

    // Single pop.
    do_op(1'b1, 32'd0);
    #1;
    chk1("pop_re", mem_re, 1'b1);
    chk ("pop_addr", mem_addr, 32'd256);
    chk ("pop_new_top", new_top, 32'd256);
    @(posedge clk);
    #2;
    chk1("pop_wb_no_valid", pop_valid, 1'b0);
    @(posedge clk);
    #2;
    chk1("pop_valid", pop_valid, 1'b1);
    chk ("pop_data", pop_data, 32'hDEADBEEF);

    // Back-to-back push A, push B, pop, pop.
    do_op(1'b0, 32'hAAAA_0001);
    do_op(1'b0, 32'hBBBB_0002);
    do_op(1'b1, 32'd0);
    do_op(1'b1, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk1("b2b_last_valid", pop_valid, 1'b1);
    chk ("b2b_last_data", pop_data, 32'hAAAA_0001);
    @(posedge clk);
    #2;
    chk ("b2b_sp_end", sp_top, 32'd256);
    chk ("b2b_hold_data", pop_data, 32'hAAAA_0001);

`ifdef STACK_BOUNDS_CHECK_EN
    // Underflow.
    do_op(1'b1, 32'd0);
    #1;
    chk1("unf_no_re", mem_re, 1'b0);
    chk ("unf_new_top", new_top, 32'd256);
    @(posedge clk);
    #2;
    chk1("unf_err", err, 1'b1);
    chk1("unf_no_valid", pop_valid, 1'b0);
    chk1("unf_ready", req_ready, 1'b1);
    @(posedge clk);
    #2;
    chk1("unf_no_valid2", pop_valid, 1'b0);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    #1;
    chk1("clr_err", err, 1'b0);

    // Overflow at a full stack, then set-beats-clear.
    sp_load_val = 32'd512;
    sp_load     = 1'b1;
    @(posedge clk);
    #1 sp_load = 1'b0;
    chk ("ovf_sp", sp_top, 32'd512);
    do_op(1'b0, 32'h0BAD_F00D);
    #1;
    chk1("ovf_no_we", mem_we, 1'b0);
    chk ("ovf_new_top", new_top, 32'd512);
    @(posedge clk);
    #2;
    chk1("ovf_err", err, 1'b1);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    #1;
    chk1("ovf_clr", err, 1'b0);
    do_op(1'b0, 32'h0BAD_F00E);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    #1;
    chk1("set_beats_clr", err, 1'b1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
`endif

    // Reset in the middle of a pop.
    do_op(1'b0, 32'hCAFE_0001);
    do_op(1'b1, 32'd0);
    #1;
    chk1("pre_rst_re", mem_re, 1'b1);
    rst = 1'b1;
    #1;
    chk1("midop_re", mem_re, 1'b0);
    chk1("midop_we", mem_we, 1'b0);
    chk ("midop_new_top", new_top, 32'd256);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #2;
      chk1("midop_no_valid", pop_valid, 1'b0);
    end

    // Randomized traffic against the model.
    depth = 0;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        err_clr = ($urandom_range(0, 3) == 0);
        @(posedge clk);
        #1;
      end
      err_clr = ($urandom_range(0, 4) == 0);
      op = $urandom_range(0, 1);
      if (!BOUNDS && depth == 0) op = 1'b0;
      if (depth >= 200) op = 1'b1;
      do_op(op, $urandom);
      if (!op) depth++;
      else if (depth > 0) depth--;
    end
    err_clr = 1'b0;
    repeat (5) @(posedge clk);
    #2;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
